// File: rtl/rst_sequencer_pkg.sv
// rtl/rst_sequencer_pkg.sv - shared types and width helpers for the reset sequencer
//
// Purpose: state encoding and width-derivation helpers used by rst_sequencer.
// Ports:   none (package).

package rst_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  // ceil(log2(v)) but never below one bit, so a degenerate range still gets a real signal.
  function automatic int clog2_min1(input int v);
    if (v <= 2) return 1;
    return $clog2(v);
  endfunction

  function automatic int cnt_width(input int hold_cycles, input int timeout_cycles);
    return clog2_min1((hold_cycles > timeout_cycles) ? hold_cycles : timeout_cycles);
  endfunction

  function automatic int idx_width(input int n_stages);
    return clog2_min1(n_stages);
  endfunction

  function automatic int retry_width(input int max_retry);
    return clog2_min1(max_retry);
  endfunction

endpackage

// File: rtl/rst_sequencer.sv
// rtl/rst_sequencer.sv - ordered reset release of N downstream stages
//
// Purpose: holds every stage in reset for HOLD_CYCLES, then releases stages one at a
//          time, waiting for each stage_ready before releasing the next. Timeouts
//          retry the whole sequence up to MAX_RETRY times before latching FAULT.
// Ports:
//   clk_out      in   PLL-derived clock
//   arst         in   asynchronous active-high reset
//   sw_rst_req   in   one-cycle request for a full re-sequence
//   stage_ready  in   per-stage alive status (already synchronised)
//   stage_rst    out  per-stage reset, active-high
//   all_ready    out  high in RUN
//   busy         out  high in HOLD or WAIT
//   timeout_err  out  sticky timeout flag
//   ready_lost   out  sticky flag: a released stage dropped ready
//   fault        out  high in FAULT
//   fail_stage   out  index of the last stage that timed out

module rst_sequencer
  import rst_sequencer_pkg::*;
#(
  parameter int N_STAGES       = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int MAX_RETRY      = 3
) (
  input  logic                        clk_out,
  input  logic                        arst,
  input  logic                        sw_rst_req,
  input  logic [N_STAGES-1:0]         stage_ready,
  output logic [N_STAGES-1:0]         stage_rst,
  output logic                        all_ready,
  output logic                        busy,
  output logic                        timeout_err,
  output logic                        ready_lost,
  output logic                        fault,
  output logic [$clog2(N_STAGES)-1:0] fail_stage
);

  localparam int CW = cnt_width(HOLD_CYCLES, TIMEOUT_CYCLES);
  localparam int KW = idx_width(N_STAGES);
  localparam int RW = retry_width(MAX_RETRY);

  localparam logic [CW-1:0] HOLD_LAST    = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX      = '1;
  localparam logic [KW-1:0] K_LAST       = KW'(N_STAGES - 1);
  localparam logic [RW-1:0] RETRY_LAST   = RW'(MAX_RETRY - 1);

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d, cnt_inc;
  logic [KW-1:0]         k_q, k_d;
  logic [RW-1:0]         retry_q, retry_d;
  logic [N_STAGES-1:0]   stage_rst_q, stage_rst_d;
  logic                  all_ready_q, all_ready_d;
  logic                  busy_q, busy_d;
  logic                  timeout_err_q, timeout_err_d;
  logic                  ready_lost_q, ready_lost_d;
  logic                  fault_q, fault_d;
  logic [KW-1:0]         fail_stage_q, fail_stage_d;
  logic                  lower_lost;

  // Reset vector while waiting on stage idx: stages 0..idx released, the rest held.
  function automatic logic [N_STAGES-1:0] held_above(input logic [KW-1:0] idx);
    logic [N_STAGES-1:0] m;
    m = '0;
    for (int i = 0; i < N_STAGES; i++) begin
      m[i] = (i > int'(idx));
    end
    return m;
  endfunction

  // Saturating increment: the counter never wraps back into a "fresh" count.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

  // A stage released before the one currently being waited on has dropped ready.
  always_comb begin
    lower_lost = 1'b0;
    for (int i = 0; i < N_STAGES; i++) begin
      if ((i < int'(k_q)) && !stage_ready[i]) begin
        lower_lost = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    k_d           = k_q;
    retry_d       = retry_q;
    timeout_err_d = timeout_err_q;
    ready_lost_d  = ready_lost_q;
    fail_stage_d  = fail_stage_q;

    if (sw_rst_req) begin
      state_d       = ST_HOLD;
      cnt_d         = '0;
      k_d           = '0;
      retry_d       = '0;
      timeout_err_d = 1'b0;
      ready_lost_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = ST_WAIT;
            cnt_d   = '0;
            k_d     = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_WAIT: begin
          // Losing an already-released stage invalidates the sequence, so it outranks progress.
          if (lower_lost) begin
            ready_lost_d = 1'b1;
            state_d      = ST_HOLD;
            cnt_d        = '0;
            k_d          = '0;
          end else if (stage_ready[k_q]) begin
            cnt_d = '0;
            if (k_q == K_LAST) begin
              state_d = ST_RUN;
            end else begin
              k_d = k_q + KW'(1);
            end
          end else if (cnt_q == TIMEOUT_LAST) begin
            timeout_err_d = 1'b1;
            fail_stage_d  = k_q;
            cnt_d         = '0;
            k_d           = '0;
            if (retry_q == RETRY_LAST) begin
              state_d = ST_FAULT;
            end else begin
              retry_d = retry_q + RW'(1);
              state_d = ST_HOLD;
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_RUN: begin
          if (!(&stage_ready)) begin
            ready_lost_d = 1'b1;
            state_d      = ST_HOLD;
            cnt_d        = '0;
            k_d          = '0;
          end
        end
        ST_FAULT: begin
          state_d = ST_FAULT;
        end
        default: begin
          state_d = ST_HOLD;
          cnt_d   = '0;
          k_d     = '0;
        end
      endcase
    end

    // Outputs follow the next state so they are registered alongside it.
    unique case (state_d)
      ST_WAIT: stage_rst_d = held_above(k_d);
      ST_RUN:  stage_rst_d = '0;
      default: stage_rst_d = '1;
    endcase
    all_ready_d = (state_d == ST_RUN);
    busy_d      = (state_d == ST_HOLD) || (state_d == ST_WAIT);
    fault_d     = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk_out or posedge arst) begin
    if (arst) begin
      state_q       <= ST_HOLD;
      cnt_q         <= '0;
      k_q           <= '0;
      retry_q       <= '0;
      stage_rst_q   <= '1;
      all_ready_q   <= 1'b0;
      busy_q        <= 1'b1;
      timeout_err_q <= 1'b0;
      ready_lost_q  <= 1'b0;
      fault_q       <= 1'b0;
      fail_stage_q  <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      k_q           <= k_d;
      retry_q       <= retry_d;
      stage_rst_q   <= stage_rst_d;
      all_ready_q   <= all_ready_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
      ready_lost_q  <= ready_lost_d;
      fault_q       <= fault_d;
      fail_stage_q  <= fail_stage_d;
    end
  end

  assign stage_rst   = stage_rst_q;
  assign all_ready   = all_ready_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;
  assign ready_lost  = ready_lost_q;
  assign fault       = fault_q;
  assign fail_stage  = fail_stage_q;

endmodule

// File: doc/rst_sequencer.md
Name: rst_sequencer

Overview:
- Sequences ordered reset release of N downstream stages (e.g. PHY, MAC, DMA, app) after the PLL-derived clock is stable.
- Releases stages one at a time: hold all → release stage k → wait stage_ready[k] → release k+1.
- Provides bounded retry on timeout, a fault latch, and a software-requested full re-sequence.
- Sits directly downstream of the PLL/reset generator, driven by its clk_out and arst.

Parameters:
- N_STAGES, 4, number of sequenced reset domains (2..8).
- HOLD_CYCLES, 16, cycles all resets stay asserted before stage 0 is released (>=2).
- TIMEOUT_CYCLES, 1024, max cycles to wait for stage_ready[k] after releasing stage k (>=2).
- MAX_RETRY, 3, timeout-triggered re-sequences allowed before entering FAULT (>=1).

Ports:
- clk_out  in  1  system clock from PLL.
- arst  in  1  reset, asynchronous, active-high; clock clk_out.
- sw_rst_req  in  1  single-cycle request for full re-sequence, synchronous to clk_out.
- stage_ready  in  N_STAGES  per-stage "out of reset and alive" status. Synchronous to clk_out; synchronisers are external.
- stage_rst  out  N_STAGES  per-stage reset, active-high, registered.
- all_ready  out  1  high while in RUN.
- busy  out  1  high in HOLD or WAIT.
- timeout_err  out  1  sticky; set on any timeout.
- ready_lost  out  1  sticky; set when a released stage drops ready.
- fault  out  1  high in FAULT.
- fail_stage  out  $clog2(N_STAGES)  index of the last stage that timed out.

Behaviour:
- All outputs are registers.
- Reset values (arst high, asynchronous):
  - state=HOLD, stage_rst=all 1s, cnt=0, k=0, retry=0.
  - all_ready=0, busy=1, timeout_err=0, ready_lost=0, fault=0, fail_stage=0.
- States: HOLD, WAIT, RUN, FAULT.
- HOLD:
  - All stage_rst=1; cnt increments each edge.
  - On the edge where cnt==HOLD_CYCLES-1: stage_rst[0]<=0, k<=0, cnt<=0, go WAIT.
  - Result: stage_rst[0] falls on the HOLD_CYCLES-th rising edge after arst deasserts.
- WAIT (stage k released, stages >k held):
  - stage_ready[k]==1 sampled, k<N-1: stage_rst[k+1]<=0, k<=k+1, cnt<=0. Release latency is one edge.
  - stage_ready[k]==1 sampled, k==N-1: go RUN and set all_ready. retry is not cleared.
  - cnt==TIMEOUT_CYCLES-1 with no ready: timeout_err<=1, fail_stage<=k, all stage_rst<=1, cnt<=0.
    - If retry==MAX_RETRY-1: go FAULT.
    - Otherwise retry++ and go HOLD.
  - Ready and timeout on the same edge: ready wins.
  - Any stage_ready[j]==0 for j<k: ready_lost<=1, all stage_rst<=1, go HOLD. retry unchanged.
- RUN:
  - stage_rst all 0.
  - Any stage_ready bit 0: ready_lost<=1, all stage_rst<=1, all_ready<=0, go HOLD.
- FAULT:
  - All stage_rst=1, fault=1.
  - Leaves only via sw_rst_req or arst.
- sw_rst_req, any state, highest priority below arst:
  - Next edge: all stage_rst<=1, state=HOLD, cnt=0, k=0, retry=0.
  - Clears timeout_err, ready_lost, fault; fail_stage is kept.
  - A request while already in HOLD restarts the hold count.
- arst mid-sequence: every stage_rst asserts immediately (asynchronously); the sequence restarts from HOLD.
- Stages never release out of order; at most one stage is newly released per edge.
- Counter width: $clog2(max(HOLD_CYCLES,TIMEOUT_CYCLES)). The counter saturates rather than wraps.

Decomposition:
- Package rst_sequencer_pkg:
  - state enum (HOLD, WAIT, RUN, FAULT), 2-bit encoding.
  - Localparam helper functions for counter, index and retry widths.
- Single flat module; no sub-module needed. ready_lost/timeout checks stay inline.

Test Plan:
- Nominal: N=4, HOLD=16, TIMEOUT=64. arst released; each stage_ready rises 5 cycles after its stage_rst falls → stage_rst[0] falls at edge 16, then stages 1, 2, 3 each fall 6 edges after the previous; all_ready=1 on the edge after stage_ready[3]; busy=0.
- Timeout/retry: stage_ready[2] held low, MAX_RETRY=3 → timeout_err=1, fail_stage=2, all stage_rst=1 after 64 WAIT cycles; three sequences run, then fault=1 with stage_rst=4'b1111 held.
- Fault recovery: in FAULT, pulse sw_rst_req with all readies now responsive → fault=0, timeout_err=0, full sequence completes, all_ready=1.
- Ready lost: in RUN, drop stage_ready[1] for 1 cycle → next edge stage_rst=4'b1111, all_ready=0, ready_lost=1; re-sequence completes.
- Async reset mid-WAIT: assert arst at k=2 between clock edges → stage_rst=4'b1111 before the next edge; after release, restart timing matches the nominal case.
- Simultaneous: stage_ready[k] rises on the same edge cnt hits TIMEOUT-1 → advance, no timeout_err. sw_rst_req on the same edge as the final ready → HOLD, all_ready stays 0.
